// File: rtl/neokeon_pkg.sv
// Shared Neokeon word type and rotate helpers used by the Theta/Pi1/Pi2 datapath blocks.
package neokeon_pkg;

    localparam int NK_WORD_W = 32;

    typedef logic [NK_WORD_W-1:0] nk_word_t;

    // Bit i of the result takes bit (i+n) mod 32 of the input; n=0 is identity.
    function automatic nk_word_t rotr(input nk_word_t x, input int n);
        nk_word_t r;
        r = '0;
        for (int i = 0; i < NK_WORD_W; i++) begin
            r[i] = x[(i + n) % NK_WORD_W];
        end
        return r;
    endfunction

    function automatic nk_word_t rotl(input nk_word_t x, input int n);
        return rotr(x, (NK_WORD_W - (n % NK_WORD_W)) % NK_WORD_W);
    endfunction

endpackage

// File: rtl/nk_valid_reg.sv
// Generic data+valid pipeline register: data captured only on valid, held otherwise;
// synchronous active-low reset clears both.
module nk_valid_reg #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/neokeon_rotr32_by2_fun.sv
// Fixed rotate-right of a 32-bit Neokeon word, optionally behind a valid-qualified register.
module neokeon_rotr32_by2_fun
    import neokeon_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ROT     = 2,
    parameter int REG_OUT = 1
) (
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inDataWord,
    output logic [DATA_W-1:0] outputData,
    output logic              outValid
);

    if (DATA_W != NK_WORD_W) begin : g_bad_width
        $error("neokeon_rotr32_by2_fun: DATA_W must be 32");
    end
    if (ROT < 0 || ROT >= DATA_W) begin : g_bad_rot
        $error("neokeon_rotr32_by2_fun: ROT must be in 0..DATA_W-1");
    end

    nk_word_t w_rot;

    assign w_rot = rotr(inDataWord, ROT);

    if (REG_OUT != 0) begin : g_reg
        nk_valid_reg #(
            .DATA_W (DATA_W)
        ) u_out_reg (
            .i_clk   (inClk),
            .i_rst_n (inRstN),
            .i_valid (inValid),
            .i_data  (w_rot),
            .o_data  (outputData),
            .o_valid (outValid)
        );
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic w_unused;
        assign w_unused   = &{1'b0, inClk, inRstN};
        assign outputData = w_rot;
        assign outValid   = inValid;
    end

endmodule

// File: tb/tb_neokeon_rotr32_by2_fun.sv
// Directed bench for the registered, combinational and ROT=0 builds of the rotate block.
module tb_neokeon_rotr32_by2_fun;

    logic        clk;
    logic        rst_n;
    logic        vld_r;
    logic [31:0] din_r;
    logic [31:0] dout_r;
    logic        vout_r;

    logic        vld_c;
    logic [31:0] din_c;
    logic [31:0] dout_c;
    logic        vout_c;

    logic        vld_i;
    logic [31:0] din_i;
    logic [31:0] dout_i;
    logic        vout_i;

    int checks = 0;
    int errors = 0;

    neokeon_rotr32_by2_fun #(.DATA_W(32), .ROT(2), .REG_OUT(1)) u_dut_reg (
        .inClk      (clk),
        .inRstN     (rst_n),
        .inValid    (vld_r),
        .inDataWord (din_r),
        .outputData (dout_r),
        .outValid   (vout_r)
    );

    neokeon_rotr32_by2_fun #(.DATA_W(32), .ROT(2), .REG_OUT(0)) u_dut_comb (
        .inClk      (clk),
        .inRstN     (rst_n),
        .inValid    (vld_c),
        .inDataWord (din_c),
        .outputData (dout_c),
        .outValid   (vout_c)
    );

    neokeon_rotr32_by2_fun #(.DATA_W(32), .ROT(0), .REG_OUT(0)) u_dut_id (
        .inClk      (clk),
        .inRstN     (rst_n),
        .inValid    (vld_i),
        .inDataWord (din_i),
        .outputData (dout_i),
        .outValid   (vout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wrap_in  [4] = '{32'h00000001, 32'h00000003, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] wrap_exp [4] = '{32'h40000000, 32'hC0000000, 32'h20000000, 32'hFFFFFFFF};
    logic [31:0] x;
    logic [31:0] chain;
    logic        v;
    int          comb_bad;

    initial begin
        rst_n = 1'b0; vld_r = 1'b1; din_r = 32'hFFFFFFFF;
        vld_c = 1'b0; din_c = 32'h0; vld_i = 1'b0; din_i = 32'h0;

        // Reset held for two edges with valid asserted.
        step();
        step();
        check("reset_data", dout_r, 32'h00000000);
        check("reset_valid", {31'b0, vout_r}, 32'h0);

        rst_n = 1'b1;
        din_r = 32'h1111AAAA; vld_r = 1'b1;
        step();
        check("ref_data", dout_r, 32'h84446AAA);
        check("ref_valid", {31'b0, vout_r}, 32'h1);

        vld_r = 1'b0; din_r = 32'h12345678;
        step();
        check("hold_data", dout_r, 32'h84446AAA);
        check("hold_valid", {31'b0, vout_r}, 32'h0);

        for (int i = 0; i < 4; i++) begin
            din_r = wrap_in[i]; vld_r = 1'b1;
            step();
            check($sformatf("wrap%0d_data", i), dout_r, wrap_exp[i]);
            check($sformatf("wrap%0d_valid", i), {31'b0, vout_r}, 32'h1);
        end

        din_r = 32'h00000001; step();
        check("stream0", dout_r, 32'h40000000);
        check("stream0_valid", {31'b0, vout_r}, 32'h1);
        din_r = 32'h00000002; step();
        check("stream1", dout_r, 32'h80000000);
        check("stream1_valid", {31'b0, vout_r}, 32'h1);
        din_r = 32'h00000004; step();
        check("stream2", dout_r, 32'h00000001);
        check("stream2_valid", {31'b0, vout_r}, 32'h1);

        // Reset wins over a valid word in the same cycle.
        rst_n = 1'b0; din_r = 32'hA5A5A5A5; vld_r = 1'b1;
        step();
        check("midrst_data", dout_r, 32'h00000000);
        check("midrst_valid", {31'b0, vout_r}, 32'h0);
        rst_n = 1'b1; din_r = 32'h80000000;
        step();
        check("post_rst_data", dout_r, 32'h20000000);
        check("post_rst_valid", {31'b0, vout_r}, 32'h1);

        // Combinational build against the shift/or reference.
        comb_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            v = 1'($urandom_range(0, 1));
            din_c = x; vld_c = v;
            #1;
            if (dout_c !== ((x >> 2) | (x << 30)) || vout_c !== v) begin
                comb_bad++;
                if (comb_bad <= 5)
                    $display("FAIL comb_rand x=%h observed=%h/%b expected=%h/%b",
                             x, dout_c, vout_c, (x >> 2) | (x << 30), v);
            end
        end
        check("comb_rand_mismatches", comb_bad, 32'd0);

        din_c = 32'h1111AAAA; vld_c = 1'b1; #1;
        check("comb_ref", dout_c, 32'h84446AAA);
        check("comb_valid", {31'b0, vout_c}, 32'h1);

        chain = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) begin
            din_c = chain; #1;
            chain = dout_c;
            if (i == 0) check("chain_first", chain, 32'hF7AB6FBB);
        end
        check("chain16", chain, 32'hDEADBEEF);

        din_c = 32'h00000000; #1;
        check("comb_zero", dout_c, 32'h00000000);

        din_i = 32'hDEADBEEF; vld_i = 1'b1; #1;
        check("rot0_identity", dout_i, 32'hDEADBEEF);
        check("rot0_valid", {31'b0, vout_i}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/neokeon_rotr32_by2_fun.md
Name: neokeon_rotr32_by2_fun

Overview:
- Fixed 32-bit rotate-right-by-2 primitive used by the Neokeon128 round datapath.
- The rotate itself is pure wiring.
- The block registers the result behind a one-cycle valid-qualified stage so it can sit between pipeline registers in the round core.
- An optional bypass parameter exposes the purely combinational result for use inside a single-cycle round.

Parameters:
- DATA_W, 32, word width; only 32 is supported; any other value is an elaboration error.
- ROT, 2, rotate-right amount; legal range 0..DATA_W-1; 0 means pass-through.
- REG_OUT, 1, 1 = registered output (latency 1); 0 = combinational output (latency 0).

Ports:
- inClk  input  1  single clock; all state updates on rising edge.
- inRstN  input  1  synchronous reset, active-low.
- inValid  input  1  qualifies inDataWord this cycle.
- inDataWord  input  32  word to rotate.
- outputData  output  32  rotated word.
- outValid  output  1  qualifies outputData.

Behaviour:
- Function: outputData = {inDataWord[ROT-1:0], inDataWord[DATA_W-1:ROT]}.
  - With defaults: outputData = {inDataWord[1:0], inDataWord[31:2]}.
  - Equivalent to (x >> 2) | (x << 30) modulo 2^32.
  - No arithmetic, no sign handling; bits wrap from LSB end to MSB end.
- REG_OUT=1:
  - On rising inClk with inRstN=0: outputData <= 32'h0, outValid <= 0.
  - On rising inClk with inRstN=1 and inValid=1: outputData <= rotr(inDataWord), outValid <= 1.
  - On rising inClk with inRstN=1 and inValid=0: outputData holds its previous value, outValid <= 0.
  - Latency exactly 1 cycle; throughput one word per cycle; no backpressure, no ready signal.
  - Reset has priority over inValid in the same cycle.
  - Reset mid-stream discards the captured word; the first valid after reset release appears one cycle later.
  - Output values while inRstN is low but before the first edge are unspecified. After the first reset edge they are 0.
- REG_OUT=0:
  - outputData = rotr(inDataWord) combinationally; outValid = inValid.
  - inClk and inRstN are unused.
  - Output must track any input change in the same delta; no latch inferred.
- Idempotence and boundaries:
  - 16 successive applications return the original word.
  - All-zero and all-one inputs map to themselves.
  - ROT=0 gives identity.
- X-propagation: an X on inDataWord bit i appears only on output bit (i-ROT) mod 32.

Decomposition:
- Shared package neokeon_pkg holds:
  - NK_WORD_W = 32.
  - The word typedef nk_word_t (logic [31:0]).
  - A rotr/rotl pure function pair used by Theta/Pi1/Pi2 blocks.
- The rotate is done by calling the package function; no sub-module is needed.
- The optional output register may be a generic sub-module nk_valid_reg (data + valid, sync active-low reset), shared with other pipeline stages.

Test Plan:
1. Reset: hold inRstN=0 for 2 edges with inValid=1, inDataWord=32'hFFFFFFFF -> outputData=32'h00000000, outValid=0.
2. Reference vector: inDataWord=32'h1111AAAA, inValid=1 -> one edge later outputData=32'h84446AAA, outValid=1.
3. Wrap bits:
   - 32'h00000001 -> 32'h40000000.
   - 32'h00000003 -> 32'hC0000000.
   - 32'h80000000 -> 32'h20000000.
   - 32'hFFFFFFFF -> 32'hFFFFFFFF.
4. Back-to-back stream 32'h00000001, 32'h00000002, 32'h00000004 on consecutive cycles -> outputs 32'h40000000, 32'h80000000, 32'h00000001 on the following consecutive cycles, outValid held 1.
5. Hold: inValid=0 with inDataWord changing to 32'h12345678 after an output of 32'h84446AAA -> outputData stays 32'h84446AAA, outValid=0.
6. REG_OUT=0 build, 1000 random words: outputData equals (x>>2)|(x<<30) in the same timestep, outValid==inValid; also 16 chained rotations of 32'hDEADBEEF return 32'hDEADBEEF.
